// File: rtl/cu_pkg.sv
// cu_pkg: opcode/ALU encodings, FSM states and decoded control bundle for multicycle_control_unit
package cu_pkg;
  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_ADDI  = 4'b0010;
  localparam logic [3:0] OP_SUBI  = 4'b0011;
  localparam logic [3:0] OP_MUL2  = 4'b0100;
  localparam logic [3:0] OP_DIV2  = 4'b0101;
  localparam logic [3:0] OP_CLR   = 4'b0110;
  localparam logic [3:0] OP_RST   = 4'b0111;
  localparam logic [3:0] OP_MOV   = 4'b1000;
  localparam logic [3:0] OP_JMP   = 4'b1001;
  localparam logic [3:0] OP_OUT   = 4'b1010;
  localparam logic [3:0] OP_LOAD  = 4'b1011;
  localparam logic [3:0] OP_STORE = 4'b1100;
  localparam logic [3:0] OP_JZ    = 4'b1101;
  localparam logic [3:0] OP_JNZ   = 4'b1110;
  localparam logic [3:0] OP_HALT  = 4'b1111;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_MUL2 = 4'b0010;
  localparam logic [3:0] ALU_DIV2 = 4'b0011;
  localparam logic [3:0] ALU_MOV  = 4'b0100;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, RETIRE, HALT} state_t;
  typedef struct packed {
    logic [3:0] alu_opcode;
    logic       reset;
    logic       reset_all;
    logic       load;
    logic       mb_select;
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       out_en;
    logic       use_a;
    logic       use_b;
    logic       jump;
    logic       jz;
    logic       jnz;
    logic       ld_ret;
    logic       halt;
    logic       illegal;
  } ctrl_t;
endpackage

// File: rtl/cu_decoder.sv
// cu_decoder: combinational opcode -> control bundle; JZ/JNZ decoded only with CU_BRANCH_EN
module cu_decoder
  import cu_pkg::*;
#(
  parameter int OPC_W = 4
) (
  input  logic [OPC_W-1:0] opc,
  output ctrl_t            ctl
);
  // decode one opcode; anything not recognised is flagged illegal with no other control
  always_comb begin
    ctl = '0;
    case (opc)
      OPC_W'(OP_ADD), OPC_W'(OP_SUB), OPC_W'(OP_ADDI), OPC_W'(OP_SUBI): begin
        ctl.alu_opcode = opc[0] ? ALU_SUB : ALU_ADD;
        ctl.mb_select  = !opc[1];
        ctl.load       = 1'b1;
        ctl.use_a      = 1'b1;
        ctl.use_b      = 1'b1;
      end
      OPC_W'(OP_MUL2), OPC_W'(OP_DIV2): begin
        ctl.alu_opcode = opc[0] ? ALU_DIV2 : ALU_MUL2;
        ctl.load       = 1'b1;
        ctl.use_a      = 1'b1;
      end
      OPC_W'(OP_CLR): begin
        ctl.reset = 1'b1;
        ctl.use_a = 1'b1;
      end
      OPC_W'(OP_RST): ctl.reset_all = 1'b1;
      OPC_W'(OP_MOV): begin
        ctl.alu_opcode = ALU_MOV;
        ctl.mb_select  = 1'b1;
        ctl.load       = 1'b1;
        ctl.use_a      = 1'b1;
        ctl.use_b      = 1'b1;
      end
      OPC_W'(OP_JMP): ctl.jump = 1'b1;
      OPC_W'(OP_OUT): begin
        ctl.out_en = 1'b1;
        ctl.use_a  = 1'b1;
      end
      OPC_W'(OP_LOAD): begin
        ctl.mem_req  = 1'b1;
        ctl.mem_read = 1'b1;
        ctl.ld_ret   = 1'b1;
      end
      OPC_W'(OP_STORE): begin
        ctl.mem_req   = 1'b1;
        ctl.mem_write = 1'b1;
      end
`ifdef CU_BRANCH_EN
      OPC_W'(OP_JZ):  ctl.jz  = 1'b1;
      OPC_W'(OP_JNZ): ctl.jnz = 1'b1;
`endif
      OPC_W'(OP_HALT): ctl.halt = 1'b1;
      default: ctl.illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: fetch/decode/exec/retire sequencer with registered outputs; CU_BRANCH_EN enables JZ/JNZ
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int  OPC_W   = 4,
  parameter int  RADDR_W = 3,
  parameter int  PC_W    = 8,
  localparam int INSTR_W = OPC_W + 2*RADDR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [INSTR_W-1:0]   instr,
  input  logic                 instr_valid,
  output logic                 if_req,
  input  logic                 alu_zero,
  input  logic                 mem_ack,
  output logic [RADDR_W-1:0]   addr_a,
  output logic [RADDR_W-1:0]   addr_b,
  output logic                 reset,
  output logic                 reset_all,
  output logic                 load,
  output logic                 mb_select,
  output logic [3:0]           alu_opcode,
  output logic                 mem_req,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 mem_select,
  output logic [2*RADDR_W-1:0] mem_addr,
  output logic                 out_en,
  output logic                 pc_inc,
  output logic                 load_pc,
  output logic [PC_W-1:0]      pc_value,
  output logic                 halted,
  output logic                 illegal
);
  state_t state, state_nx;
  ctrl_t ctl;
  logic [INSTR_W-1:0] ir;
  logic [2*RADDR_W-1:0] operand;
  logic [RADDR_W-1:0] op_a, op_b;
  logic taken, ex, rt;
  logic nx_if_req, nx_reset, nx_reset_all, nx_load, nx_mb_select;
  logic nx_mem_req, nx_mem_read, nx_mem_write, nx_mem_select;
  logic nx_out_en, nx_pc_inc, nx_load_pc, nx_halted, nx_illegal;
  logic [RADDR_W-1:0] nx_addr_a, nx_addr_b;
  logic [3:0] nx_alu_opcode;
  logic [2*RADDR_W-1:0] nx_mem_addr;
  logic [PC_W-1:0] nx_pc_value;

  assign operand = ir[2*RADDR_W-1:0];
  assign op_a    = operand[2*RADDR_W-1 -: RADDR_W];
  assign op_b    = operand[RADDR_W-1:0];

  cu_decoder #(.OPC_W(OPC_W)) u_dec (
    .opc(ir[INSTR_W-1 -: OPC_W]),
    .ctl(ctl)
  );

`ifdef CU_BRANCH_EN
  // alu_zero is taken straight from the EXEC cycle that precedes RETIRE
  assign taken = ctl.jump | (ctl.jz & alu_zero) | (ctl.jnz & ~alu_zero);
`else
  logic unused_branch;
  assign unused_branch = alu_zero ^ ctl.jz ^ ctl.jnz;
  assign taken = ctl.jump;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end

  // instruction register, loaded only on an accepted fetch so it stays stable until the next FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ir <= '0;
    else if (state == FETCH && instr_valid) ir <= instr;
  end

  // next-state: memory ops stall in EXEC until mem_ack, HALT is terminal
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = FETCH;
      FETCH:   state_nx = instr_valid ? DECODE : FETCH;
      DECODE:  state_nx = EXEC;
      EXEC:    state_nx = (ctl.mem_req && !mem_ack) ? EXEC : RETIRE;
      RETIRE:  state_nx = ctl.halt ? HALT : FETCH;
      default: state_nx = state;
    endcase
  end

  // outputs are decoded from the state being entered so the registers line up with the state
  always_comb begin
    ex            = state_nx == EXEC;
    rt            = state_nx == RETIRE;
    nx_if_req     = state_nx == FETCH;
    nx_halted     = state_nx == HALT;
    nx_addr_a     = (ex && ctl.use_a) ? op_a : '0;
    nx_addr_b     = (ex && ctl.use_b) ? op_b : '0;
    nx_reset      = ex & ctl.reset;
    nx_reset_all  = ex & ctl.reset_all;
    nx_load       = (ex & ctl.load) | (rt & ctl.ld_ret);
    nx_mb_select  = ex & ctl.mb_select;
    nx_alu_opcode = ex ? ctl.alu_opcode : '0;
    nx_mem_req    = ex & ctl.mem_req;
    nx_mem_read   = ex & ctl.mem_read;
    nx_mem_write  = ex & ctl.mem_write;
    nx_mem_select = rt & ctl.ld_ret;
    nx_mem_addr   = (ex && ctl.mem_req) ? operand : '0;
    nx_out_en     = ex & ctl.out_en;
    nx_load_pc    = rt & taken;
    nx_pc_inc     = rt & ~taken & ~ctl.halt;
    nx_pc_value   = nx_load_pc ? PC_W'(operand) : '0;
    nx_illegal    = rt & ctl.illegal;
  end

  // output registers; async reset drops every strobe at once, including a stalled mem_req
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_req     <= 1'b0;
      addr_a     <= '0;
      addr_b     <= '0;
      reset      <= 1'b0;
      reset_all  <= 1'b0;
      load       <= 1'b0;
      mb_select  <= 1'b0;
      alu_opcode <= '0;
      mem_req    <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_select <= 1'b0;
      mem_addr   <= '0;
      out_en     <= 1'b0;
      pc_inc     <= 1'b0;
      load_pc    <= 1'b0;
      pc_value   <= '0;
      halted     <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      if_req     <= nx_if_req;
      addr_a     <= nx_addr_a;
      addr_b     <= nx_addr_b;
      reset      <= nx_reset;
      reset_all  <= nx_reset_all;
      load       <= nx_load;
      mb_select  <= nx_mb_select;
      alu_opcode <= nx_alu_opcode;
      mem_req    <= nx_mem_req;
      mem_read   <= nx_mem_read;
      mem_write  <= nx_mem_write;
      mem_select <= nx_mem_select;
      mem_addr   <= nx_mem_addr;
      out_en     <= nx_out_en;
      pc_inc     <= nx_pc_inc;
      load_pc    <= nx_load_pc;
      pc_value   <= nx_pc_value;
      halted     <= nx_halted;
      illegal    <= nx_illegal;
    end
  end
endmodule
